alu4_serial: RTL

ALU4_SERIAL -- requirements
Module: alu4_serial

---
 rtl/alu4_pkg.sv | 33 +++
 rtl/alu4_bitslice.sv | 70 +++++++
 rtl/alu4_serial.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu4_pkg
// Description : Shared op-code constants and FSM state encoding for the
//               bit-serial 4-bit ALU (alu4_serial / alu4_bitslice).
// Revision    : 1.0 - initial release
// ============================================================================
package alu4_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ADD and SUB are the only ops that use the carry chain.
  function automatic logic is_arith(input logic [2:0] op_code);
    return (op_code == OP_ADD) || (op_code == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu4_bitslice.sv
`default_nettype none
// ============================================================================
// Module      : alu4_bitslice
// Description : One bit of the serial ALU datapath. Built from gate
//               primitives; a full adder with optional b inversion serves
//               ADD/SUB, the remaining ops are single-gate functions of a/b.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_bitslice
  import alu4_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       y,
  output logic       cout
);

  wire w_sub;
  wire w_b_eff;
  wire w_and;
  wire w_or;
  wire w_xor;
  wire w_xnor;
  wire w_not;
  wire w_half;
  wire w_sum;
  wire w_gen;
  wire w_prop;
  wire w_carry;

  assign w_sub = (op == OP_SUB);

  // Logic-op gates
  and  u_and  (w_and,  a_bit, b_bit);
  or   u_or   (w_or,   a_bit, b_bit);
  xor  u_xor  (w_xor,  a_bit, b_bit);
  xnor u_xnor (w_xnor, a_bit, b_bit);
  not  u_not  (w_not,  a_bit);

  // Full adder; b is inverted for SUB so that a + ~b + cin forms a - b
  xor  u_binv (w_b_eff, b_bit, w_sub);
  xor  u_half (w_half,  a_bit, w_b_eff);
  xor  u_sum  (w_sum,   w_half, cin);
  and  u_gen  (w_gen,   a_bit, w_b_eff);
  and  u_prop (w_prop,  w_half, cin);
  or   u_cout (w_carry, w_gen, w_prop);

  // Select the slice output; carry only propagates for arithmetic ops
  always_comb begin
    y    = a_bit;
    cout = 1'b0;
    case (op)
      OP_AND:  y = w_and;
      OP_OR:   y = w_or;
      OP_XOR:  y = w_xor;
      OP_XNOR: y = w_xnor;
      OP_NOTA: y = w_not;
      OP_ADD,
      OP_SUB: begin
        y    = w_sum;
        cout = w_carry;
      end
      default: y = a_bit;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu4_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu4_serial
// Description : Bit-serial 4-bit ALU. Operands are captured on start, one bit
//               is processed per clock LSB first, and result/flags are
//               published together on completion with a one-cycle done pulse.
//               Optional flag logic is enabled by macro ALU4_SERIAL_FLAGS_EN;
//               without it c/n/z/v are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_serial
  import alu4_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic                c,
  output logic                n,
  output logic                z,
  output logic                v
);

  state_e              state_q,  state_d;
  logic [DATA_W-1:0]   a_q,      a_d;
  logic [DATA_W-1:0]   b_q,      b_d;
  logic [2:0]          op_q,     op_d;
  logic [1:0]          idx_q,    idx_d;
  logic                carry_q,  carry_d;
  logic [DATA_W-2:0]   acc_q,    acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;

  logic                w_y;
  logic                w_cout;
  logic                w_last;
  logic [DATA_W-1:0]   w_res;

  alu4_bitslice u_slice (
    .a_bit (a_q[idx_q]),
    .b_bit (b_q[idx_q]),
    .cin   (carry_q),
    .op    (op_q),
    .y     (w_y),
    .cout  (w_cout)
  );

  assign w_last = (idx_q == 2'd3);
  // Full word as it will look once the current (final) bit is shifted in
  assign w_res  = {w_y, acc_q};

  // Next-state, operand capture and serial accumulation
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = 2'd0;
          carry_d = (op == OP_SUB);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d = w_cout;
        acc_d   = {w_y, acc_q[DATA_W-2:1]};
        idx_d   = idx_q + 2'd1;
        if (w_last) begin
          state_d  = ST_DONE;
          result_d = w_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All control/datapath state; outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef ALU4_SERIAL_FLAGS_EN
  logic c_q, c_d;
  logic n_q, n_d;
  logic z_q, z_d;
  logic v_q, v_d;
  logic w_arith;

  assign w_arith = is_arith(op_q);

  // Flags are latched together with the result on the final bit; overflow
  // compares the carry into bit 3 (carry_q) with the carry out of it
  always_comb begin
    c_d = c_q;
    n_d = n_q;
    z_d = z_q;
    v_d = v_q;
    if ((state_q == ST_RUN) && w_last) begin
      c_d = w_arith & w_cout;
      v_d = w_arith & (carry_q ^ w_cout);
      n_d = w_y;
      z_d = (w_res == '0);
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      c_q <= c_d;
      n_q <= n_d;
      z_q <= z_d;
      v_q <= v_d;
    end
  end

  assign c = c_q;
  assign n = n_q;
  assign z = z_q;
  assign v = v_q;
`else
  assign c = 1'b0;
  assign n = 1'b0;
  assign z = 1'b0;
  assign v = 1'b0;
`endif

endmodule
`default_nettype wire
